// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// frame bit indices and the oversampling sample-point formula.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [3:0] BIT_START = 4'd0;

   // The majority sampler needs three edges around mid-bit, so its result settles at P/2+2.
   function automatic logic [15:0] samp_point(input logic [15:0] prescale);
      return (prescale >> 1) + 16'd2;
   endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter. edge_cnt wraps at
// prescale-1 and advances bit_cnt; clr returns both to the start bit.
module edge_bit_counter
   import uart_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      en,
   input  logic                      clr,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic                      last_edge
);

   logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
   logic [3:0]                bit_cnt_r;

   assign last_edge = (edge_cnt_r == (prescale - PRESCALE_WIDTH'(1)));
   assign edge_cnt  = edge_cnt_r;
   assign bit_cnt   = bit_cnt_r;

   // Edge/bit position tracking; clear wins over counting.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt_r <= '0;
         bit_cnt_r  <= BIT_START;
      end else if (clr) begin
         edge_cnt_r <= '0;
         bit_cnt_r  <= BIT_START;
      end else if (en) begin
         if (last_edge) begin
            edge_cnt_r <= '0;
            bit_cnt_r  <= bit_cnt_r + 4'd1;
         end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
            bit_cnt_r  <= bit_cnt_r;
         end
      end else begin
         edge_cnt_r <= edge_cnt_r;
         bit_cnt_r  <= bit_cnt_r;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing FSM: walks start, data, optional parity and stop
// bits, strobes the sampler/checkers and qualifies each frame with data_valid.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      rx_in,
   input  logic                      par_en,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      strt_glitch,
   input  logic                      par_err,
   input  logic                      stp_err,
   output logic                      dat_samp_en,
   output logic                      strt_chk_en,
   output logic                      par_chk_en,
   output logic                      stp_chk_en,
   output logic                      deser_en,
   output logic                      data_valid,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic                      busy
);

   logic [2:0]                state_r;
   logic [2:0]                state_nxt_s;
   logic [PRESCALE_WIDTH-1:0] presc_r;
   logic                      par_en_r;
   logic                      last_edge_s;
   logic                      samp_hit_s;
   logic                      start_det_s;
   logic                      frame_end_s;
   logic                      active_s;

   assign active_s    = (state_r != ST_IDLE);
   assign samp_hit_s  = (16'(edge_cnt) == samp_point(16'(presc_r)));
   // A new frame may also begin in the final STOP cycle (back-to-back frames).
   assign start_det_s = ~rx_in & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & last_edge_s));
   assign frame_end_s = last_edge_s & (((state_r == ST_START) & strt_glitch) | (state_r == ST_STOP));

   edge_bit_counter #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_edge_bit_counter (
      .CLK       (CLK),
      .RST       (RST),
      .en        (active_s),
      .clr       (frame_end_s),
      .prescale  (presc_r),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .last_edge (last_edge_s)
   );

   // Next-state decision, taken only at bit boundaries once a frame is running.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!rx_in) state_nxt_s = ST_START;
            else        state_nxt_s = ST_IDLE;
         end
         ST_START: begin
            if (last_edge_s) state_nxt_s = strt_glitch ? ST_IDLE : ST_DATA;
            else             state_nxt_s = ST_START;
         end
         ST_DATA: begin
            if (last_edge_s && (bit_cnt == 4'(DATA_WIDTH))) state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
            else                                            state_nxt_s = ST_DATA;
         end
         ST_PARITY: begin
            if (last_edge_s) state_nxt_s = ST_STOP;
            else             state_nxt_s = ST_PARITY;
         end
         ST_STOP: begin
            if (last_edge_s) state_nxt_s = rx_in ? ST_IDLE : ST_START;
            else             state_nxt_s = ST_STOP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register plus per-frame capture of parity mode and prescale.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r  <= ST_IDLE;
         presc_r  <= '0;
         par_en_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (start_det_s) begin
            presc_r  <= prescale;
            par_en_r <= par_en;
         end else begin
            presc_r  <= presc_r;
            par_en_r <= par_en_r;
         end
      end
   end

   assign busy        = active_s;
   assign dat_samp_en = active_s;
   assign strt_chk_en = (state_r == ST_START)  & samp_hit_s;
   assign deser_en    = (state_r == ST_DATA)   & samp_hit_s;
   assign par_chk_en  = (state_r == ST_PARITY) & samp_hit_s;
   assign stp_chk_en  = (state_r == ST_STOP)   & samp_hit_s;
   assign data_valid  = (state_r == ST_STOP) & last_edge_s & ~stp_err & ~(par_en_r & par_err);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with behavioural start/parity/stop checkers
// and a deserializer model driven by the DUT enables.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rx_in = 1'b1;
   logic       par_en = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       strt_glitch, par_err, stp_err;
   logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, busy;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK(CLK), .RST(RST), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
      .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
      .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .deser_en(deser_en), .data_valid(data_valid),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .busy(busy)
   );

   // Registered checker and deserializer models (even parity, LSB first).
   logic [7:0] shreg_r;
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         strt_glitch <= 1'b0; par_err <= 1'b0; stp_err <= 1'b0; shreg_r <= 8'h00;
      end else begin
         if (strt_chk_en) strt_glitch <= rx_in;
         if (par_chk_en)  par_err     <= rx_in ^ (^shreg_r);
         if (stp_chk_en)  stp_err     <= ~rx_in;
         if (deser_en)    shreg_r     <= {rx_in, shreg_r[7:1]};
      end
   end

   // Event monitor sampled on the inactive edge.
   logic       mon_clr = 1'b0;
   int         n_deser, n_dv, n_busy, n_strt, n_par, n_stp;
   logic [3:0] dv_bit, par_bit;
   logic [5:0] dv_edge, par_edge;
   logic [7:0] dv_data0, dv_data1;
   always @(negedge CLK) begin
      if (mon_clr) begin
         n_deser <= 0; n_dv <= 0; n_busy <= 0; n_strt <= 0; n_par <= 0; n_stp <= 0;
         dv_bit <= 4'd0; dv_edge <= 6'd0; par_bit <= 4'd0; par_edge <= 6'd0;
         dv_data0 <= 8'h00; dv_data1 <= 8'h00;
      end else begin
         if (deser_en)    n_deser <= n_deser + 1;
         if (busy)        n_busy  <= n_busy + 1;
         if (strt_chk_en) n_strt  <= n_strt + 1;
         if (stp_chk_en)  n_stp   <= n_stp + 1;
         if (par_chk_en) begin
            n_par <= n_par + 1; par_bit <= bit_cnt; par_edge <= edge_cnt;
         end
         if (data_valid) begin
            n_dv <= n_dv + 1; dv_bit <= bit_cnt; dv_edge <= edge_cnt;
            if (n_dv == 0) dv_data0 <= shreg_r;
            else           dv_data1 <= shreg_r;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge CLK);
      #1 mon_clr = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] data, input int p, input logic par,
                             input logic par_flip, input logic stop_val);
      prescale = 6'(p);
      par_en   = par;
      rx_in    = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         rx_in = data[i];
         tick(p);
      end
      if (par) begin
         rx_in = (^data) ^ par_flip;
         tick(p);
      end
      rx_in = stop_val;
      tick(p);
   endtask

   initial begin
      #2 RST = 1'b0;
      #1;
      check_val("rst_busy",    32'(busy), 32'd0);
      check_val("rst_samp",    32'(dat_samp_en), 32'd0);
      check_val("rst_edge",    32'(edge_cnt), 32'd0);
      check_val("rst_bit",     32'(bit_cnt), 32'd0);
      check_val("rst_pulses",  32'({strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}), 32'd0);
      tick(3);
      RST = 1'b1;
      tick(3);

      // P=8, no parity, 0xA5
      clear_mon();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      rx_in = 1'b1;
      tick(12);
      check_val("a5_deser", 32'(n_deser), 32'd8);
      check_val("a5_dv",    32'(n_dv), 32'd1);
      check_val("a5_busy",  32'(n_busy), 32'd80);
      check_val("a5_data",  32'(dv_data0), 32'hA5);
      check_val("a5_dvpos", 32'({dv_bit, 2'b00, dv_edge}), 32'({4'd9, 2'b00, 6'd7}));
      check_val("a5_chk",   32'({n_strt[3:0], n_par[3:0], n_stp[3:0]}), 32'h101);

      // P=16, parity enabled, correct parity
      clear_mon();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
      rx_in = 1'b1;
      tick(20);
      check_val("3c_parpos", 32'({par_bit, 2'b00, par_edge}), 32'({4'd9, 2'b00, 6'd10}));
      check_val("3c_dv",     32'(n_dv), 32'd1);
      check_val("3c_dvpos",  32'({dv_bit, 2'b00, dv_edge}), 32'({4'd10, 2'b00, 6'd15}));
      check_val("3c_busy",   32'(n_busy), 32'd176);
      check_val("3c_data",   32'(dv_data0), 32'h3C);

      // P=16, wrong parity bit
      clear_mon();
      send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
      rx_in = 1'b1;
      tick(20);
      check_val("badpar_par", 32'(n_par), 32'd1);
      check_val("badpar_dv",  32'(n_dv), 32'd0);

      // P=8, stop bit 0, line stays low into next START then recovers high
      clear_mon();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
      tick(1);
      rx_in = 1'b1;
      tick(12);
      check_val("stp0_dv",    32'(n_dv), 32'd0);
      check_val("stp0_strt",  32'(n_strt), 32'd2);
      check_val("stp0_deser", 32'(n_deser), 32'd8);
      check_val("stp0_busy",  32'(n_busy), 32'd88);
      check_val("stp0_idle",  32'({busy, bit_cnt, edge_cnt}), 32'd0);

      // P=16, 2-cycle low glitch
      clear_mon();
      prescale = 6'd16;
      rx_in = 1'b0;
      tick(2);
      rx_in = 1'b1;
      tick(24);
      check_val("gl_busy",  32'(n_busy), 32'd16);
      check_val("gl_deser", 32'(n_deser), 32'd0);
      check_val("gl_strt",  32'(n_strt), 32'd1);
      check_val("gl_dv",    32'(n_dv), 32'd0);

      // Back-to-back frames, P=8
      clear_mon();
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
      rx_in = 1'b1;
      tick(12);
      check_val("b2b_dv",    32'(n_dv), 32'd2);
      check_val("b2b_busy",  32'(n_busy), 32'd160);
      check_val("b2b_data0", 32'(dv_data0), 32'h55);
      check_val("b2b_data1", 32'(dv_data1), 32'hFF);
      check_val("b2b_deser", 32'(n_deser), 32'd16);

      // Reset during bit 4, then a fresh frame
      clear_mon();
      prescale = 6'd8;
      par_en   = 1'b0;
      rx_in    = 1'b0;
      tick(8);
      rx_in = 1'b1; tick(8);
      rx_in = 1'b0; tick(8);
      rx_in = 1'b1; tick(8);
      tick(4);
      check_val("mid_bit", 32'(bit_cnt), 32'd4);
      RST = 1'b0;
      #1;
      check_val("mid_rst_out", 32'({busy, dat_samp_en, deser_en, strt_chk_en, data_valid}), 32'd0);
      check_val("mid_rst_cnt", 32'({bit_cnt, edge_cnt}), 32'd0);
      rx_in = 1'b1;
      tick(3);
      RST = 1'b1;
      tick(4);
      check_val("mid_dv", 32'(n_dv), 32'd0);
      clear_mon();
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
      rx_in = 1'b1;
      tick(12);
      check_val("post_dv",   32'(n_dv), 32'd1);
      check_val("post_data", 32'(dv_data0), 32'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
